// File: rtl/iomem_initiator_if.sv
// iomem bus bundle shared by the initiator and the PicoSoC iomem responders.
// The master side issues requests; the slave side returns the ready strobe
// and read data.
interface iomem_initiator_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface

// File: rtl/iomem_initiator.sv
// iomem_initiator: turns one fabric command into one iomem read/write
// transaction and returns a single response (read data or timeout error).
// Define IOMEM_INITIATOR_TIMEOUT_EN to build the bounded-wait counter; without
// it the bus phase waits for iomem_ready indefinitely and rsp_err is tied 0.
module iomem_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,

    iomem_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        cmd_fire;
    logic        bus_ack;
    logic        timeout_hit;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("iomem_initiator: TIMEOUT must be in 1..65535");
    end

    assign cmd_fire = (state == IDLE) && cmd_valid && cmd_ready;
    assign bus_ack  = (state == BUS) && bus.iomem_ready;

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt;
    logic        err_q;

    // The counter holds the number of BUS edges already seen, so the edge that
    // would close the TIMEOUT-th valid cycle is the one where it equals TIMEOUT-1.
    assign timeout_hit = (state == BUS) && (wait_cnt == LAST_CNT);

    // Wait counter: cleared on accept, advances once per BUS cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (cmd_fire) begin
            wait_cnt <= '0;
        end else if (state == BUS) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Error flag: ready wins over a coincident timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (bus_ack) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cmd_fire)                  state_next = BUS;
            BUS:     if (bus_ack || timeout_hit)    state_next = RESP;
            RESP:    if (rsp_ready)                 state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    // cmd_ready is registered from the next state so it stays low during reset
    // and first rises on the edge after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= (state_next == IDLE);
        end
    end

    // Bus request registers: loaded on accept, strobes cleared when BUS ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_fire) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end else if (bus_ack || timeout_hit) begin
            wstrb_q <= '0;
        end
    end

    // Response data: read data on a read ack, zero for writes and timeouts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (bus_ack) begin
            rdata_q <= (wstrb_q == 4'b0000) ? bus.iomem_rdata : '0;
        end else if (timeout_hit) begin
            rdata_q <= '0;
        end
    end

    assign bus.iomem_valid = (state == BUS);
    assign bus.iomem_addr  = addr_q;
    assign bus.iomem_wdata = wdata_q;
    assign bus.iomem_wstrb = wstrb_q;

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;

endmodule
